send_arbiter: RTL and testbench

Two-requester arbiter that shares one outbound data bus between two independent send/ack channels, such as the send1/data1/ack1 and send2/data2/ack2 pairs of the processor.
- Each requester runs a 4-phase handshake toward the arbiter.
- The arbiter captures the granted word, drives it onto the shared bus with its own 4-phase handshake, then returns ack to the winner.
- Round-robin fairness between the two requesters. Sits between the processor and the downstream consumer.

---
 rtl/send_arbiter_if.sv | 36 +++
 rtl/send_arbiter.sv | 189 ++++++++++++++++++
 tb/tb_send_arbiter.sv | 300 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/send_arbiter_if.sv
// -----------------------------------------------------------------------------
// send_arbiter_if
// Purpose : bundles the two requester send/data/ack channels, the shared
//           outbound bus handshake and the arbiter status flags.
// Modports: master - arbiter view (drives acks, bus side, status)
//           slave  - environment view (drives requests, data, bus_ack)
// Signals : send1/data1/ack1, send2/data2/ack2   requester channels
//           bus_send/bus_data/bus_ack            shared outbound bus
//           bus_owner, busy, timeout_err         status
// -----------------------------------------------------------------------------
interface send_arbiter_if #(
  parameter int DATA_W = 16
);
  logic              send1;
  logic [DATA_W-1:0] data1;
  logic              ack1;
  logic              send2;
  logic [DATA_W-1:0] data2;
  logic              ack2;
  logic              bus_send;
  logic [DATA_W-1:0] bus_data;
  logic              bus_ack;
  logic              bus_owner;
  logic              busy;
  logic              timeout_err;

  modport master (
    input  send1, data1, send2, data2, bus_ack,
    output ack1, ack2, bus_send, bus_data, bus_owner, busy, timeout_err
  );

  modport slave (
    output send1, data1, send2, data2, bus_ack,
    input  ack1, ack2, bus_send, bus_data, bus_owner, busy, timeout_err
  );
endinterface

// File: rtl/send_arbiter.sv
// -----------------------------------------------------------------------------
// send_arbiter
// Purpose : round-robin arbiter sharing one outbound 4-phase bus between two
//           4-phase send/ack requesters. The winning word is captured, driven
//           onto the bus, and the winner is acked once the consumer acks.
// Ports   : clk    - clock, all logic on posedge
//           rst_n  - synchronous active-low reset
//           arb    - send_arbiter_if.master (requester channels, bus, status)
// Params  : DATA_W      - word width
//           TIMEOUT_CYC - GRANT cycles without bus_ack before abort
// Option  : define ARB_TIMEOUT_EN to enable the GRANT timeout and the sticky
//           timeout_err flag; otherwise GRANT waits forever and timeout_err=0.
// -----------------------------------------------------------------------------
module send_arbiter #(
  parameter int DATA_W      = 16,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic                  clk,
  input  logic                  rst_n,
  send_arbiter_if.master        arb
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_GRANT   = 2'd1,
    ST_RELEASE = 2'd2
  } state_t;

  // Elaboration-time guard on the timeout range (counter is 16 bits wide).
  if (TIMEOUT_CYC < 1 || TIMEOUT_CYC > 65535) begin : g_bad_timeout
    $error("send_arbiter: TIMEOUT_CYC out of range 1..65535");
  end

  state_t            state_q, state_d;
  logic              owner_q, owner_d;        // 0 = requester 1, 1 = requester 2
  logic              last_grant_q, last_grant_d;
  logic [DATA_W-1:0] cap_q, cap_d;            // captured word of the current winner
  logic              bus_send_q, bus_send_d;
  logic [DATA_W-1:0] bus_data_q, bus_data_d;
  logic              ack1_q, ack1_d;
  logic              ack2_q, ack2_d;
  logic              busy_q, busy_d;

`ifdef ARB_TIMEOUT_EN
  localparam logic [15:0] TO_LIMIT = 16'(TIMEOUT_CYC);
  logic [15:0]       cnt_q, cnt_d;
  logic              terr_q, terr_d;
`endif

  logic              grant_2;     // IDLE arbitration result
  logic              owner_send;  // send line of the current owner

  // Next-state and registered-output computation.
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    cap_d        = cap_q;
    bus_send_d   = bus_send_q;
    bus_data_d   = bus_data_q;
    ack1_d       = ack1_q;
    ack2_d       = ack2_q;
    busy_d       = busy_q;
    grant_2      = 1'b0;
    owner_send   = owner_q ? arb.send2 : arb.send1;
`ifdef ARB_TIMEOUT_EN
    cnt_d        = cnt_q;
    terr_d       = terr_q;
`endif

    case (state_q)
      ST_IDLE: begin
        // Requester 2 wins when alone, or on a tie when requester 1 went last.
        grant_2 = arb.send2 & (~arb.send1 | ~last_grant_q);
        if (arb.send1 || arb.send2) begin
          owner_d      = grant_2;
          last_grant_d = grant_2;
          cap_d        = grant_2 ? arb.data2 : arb.data1;
          bus_data_d   = grant_2 ? arb.data2 : arb.data1;
          bus_send_d   = 1'b1;
          busy_d       = 1'b1;
          state_d      = ST_GRANT;
`ifdef ARB_TIMEOUT_EN
          cnt_d        = 16'd0;
`endif
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_GRANT: begin
        // The requester's send is not consulted here: a dropped send still
        // completes with the captured word.
        bus_data_d = cap_q;
        if (arb.bus_ack) begin
          bus_send_d = 1'b0;
          bus_data_d = {DATA_W{1'b0}};
          ack1_d     = ~owner_q;
          ack2_d     = owner_q;
          state_d    = ST_RELEASE;
        end else begin
`ifdef ARB_TIMEOUT_EN
          cnt_d = cnt_q + 16'd1;
          if (cnt_d == TO_LIMIT) begin
            // Abort: release the requester as if the transfer completed.
            bus_send_d = 1'b0;
            bus_data_d = {DATA_W{1'b0}};
            ack1_d     = ~owner_q;
            ack2_d     = owner_q;
            terr_d     = 1'b1;
            state_d    = ST_RELEASE;
          end else begin
            state_d = ST_GRANT;
          end
`else
          state_d = ST_GRANT;
`endif
        end
      end

      ST_RELEASE: begin
        // Both sides must have returned to zero before the ack is withdrawn.
        if (!owner_send && !arb.bus_ack) begin
          ack1_d  = 1'b0;
          ack2_d  = 1'b0;
          busy_d  = 1'b0;
          state_d = ST_IDLE;
        end else begin
          state_d = ST_RELEASE;
        end
      end

      default: begin
        state_d    = ST_IDLE;
        bus_send_d = 1'b0;
        bus_data_d = {DATA_W{1'b0}};
        ack1_d     = 1'b0;
        ack2_d     = 1'b0;
        busy_d     = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      owner_q      <= 1'b0;
      last_grant_q <= 1'b1;  // requester 1 wins the first tie
      cap_q        <= {DATA_W{1'b0}};
      bus_send_q   <= 1'b0;
      bus_data_q   <= {DATA_W{1'b0}};
      ack1_q       <= 1'b0;
      ack2_q       <= 1'b0;
      busy_q       <= 1'b0;
`ifdef ARB_TIMEOUT_EN
      cnt_q        <= 16'd0;
      terr_q       <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      cap_q        <= cap_d;
      bus_send_q   <= bus_send_d;
      bus_data_q   <= bus_data_d;
      ack1_q       <= ack1_d;
      ack2_q       <= ack2_d;
      busy_q       <= busy_d;
`ifdef ARB_TIMEOUT_EN
      cnt_q        <= cnt_d;
      terr_q       <= terr_d;
`endif
    end
  end

  assign arb.ack1      = ack1_q;
  assign arb.ack2      = ack2_q;
  assign arb.bus_send  = bus_send_q;
  assign arb.bus_data  = bus_data_q;
  assign arb.bus_owner = owner_q;
  assign arb.busy      = busy_q;
`ifdef ARB_TIMEOUT_EN
  assign arb.timeout_err = terr_q;
`else
  assign arb.timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_send_arbiter.sv
// -----------------------------------------------------------------------------
// tb_send_arbiter
// Self-checking bench for send_arbiter: a table of single transfers with a
// scoreboard of expected {owner, word}, plus hand-written sequences for
// alternation, reset in GRANT, bus_ack in IDLE and the GRANT timeout.
// -----------------------------------------------------------------------------
module tb_send_arbiter;

  localparam int DW = 16;
  localparam int TO = 8;

  logic clk;
  logic rst_n;

  send_arbiter_if #(.DATA_W(DW)) bus ();

  send_arbiter #(.DATA_W(DW), .TIMEOUT_CYC(TO)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .arb   (bus)
  );

  // Free-running clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_cmp = 0;
  int n_err = 0;
  bit mon_en = 1'b0;

  typedef struct packed {
    logic          owner;
    logic [DW-1:0] data;
  } exp_t;

  exp_t sb_q[$];

  typedef struct {
    logic          s1;
    logic          s2;
    logic [DW-1:0] d1;
    logic [DW-1:0] d2;
    logic          exp_owner;
    logic [DW-1:0] exp_data;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sb_pop(input string name);
    exp_t e;
    if (sb_q.size() == 0) begin
      check({name, "_sb_empty"}, 32'd1, 32'd0);
    end else begin
      e = sb_q.pop_front();
      check({name, "_owner"}, {31'd0, bus.bus_owner}, {31'd0, e.owner});
      check({name, "_data"}, {16'd0, bus.bus_data}, {16'd0, e.data});
    end
  endtask

  task automatic idle_inputs();
    bus.send1   = 1'b0;
    bus.send2   = 1'b0;
    bus.bus_ack = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    idle_inputs();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic check_all_zero(input string name);
    check({name, "_bus_send"}, {31'd0, bus.bus_send}, 32'd0);
    check({name, "_bus_data"}, {16'd0, bus.bus_data}, 32'd0);
    check({name, "_acks"}, {30'd0, bus.ack1, bus.ack2}, 32'd0);
    check({name, "_busy"}, {31'd0, bus.busy}, 32'd0);
    check({name, "_owner"}, {31'd0, bus.bus_owner}, 32'd0);
    check({name, "_terr"}, {31'd0, bus.timeout_err}, 32'd0);
  endtask

  // Bounded wait for bus_send; an expired bound is reported as a failure.
  task automatic wait_bus_send(input string name);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      if (bus.bus_send === 1'b1) ok = 1'b1;
      else tick();
    end
    check({name, "_bus_send_wait"}, {31'd0, ok}, 32'd1);
  endtask

  // Continuous protocol invariants: acks exclusive, no ack while bus_send.
  always @(negedge clk) begin
    if (mon_en) begin
      check("ack_exclusive", {31'd0, bus.ack1 & bus.ack2}, 32'd0);
      check("ack_vs_bus_send", {31'd0, (bus.ack1 | bus.ack2) & bus.bus_send}, 32'd0);
    end
  end

  // Global time limit.
  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, n_cmp=%0d n_err=%0d", n_cmp, n_err);
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    exp_t e;

    // Transfers run back to back from one reset; the tie results follow
    // the round-robin history (first tie goes to requester 1).
    vecs[0] = '{1'b1, 1'b0, 16'hA5A5, 16'h0000, 1'b0, 16'hA5A5};
    vecs[1] = '{1'b0, 1'b1, 16'h0000, 16'h1234, 1'b1, 16'h1234};
    vecs[2] = '{1'b1, 1'b1, 16'h0001, 16'h0002, 1'b0, 16'h0001};
    vecs[3] = '{1'b1, 1'b1, 16'h1111, 16'h2222, 1'b1, 16'h2222};
    vecs[4] = '{1'b0, 1'b1, 16'h0000, 16'hBEEF, 1'b1, 16'hBEEF};
    vecs[5] = '{1'b1, 1'b1, 16'hCAFE, 16'hF00D, 1'b0, 16'hCAFE};
    vecs[6] = '{1'b1, 1'b0, 16'hFFFF, 16'h7777, 1'b0, 16'hFFFF};
    vecs[7] = '{1'b1, 1'b1, 16'h0000, 16'h8001, 1'b1, 16'h8001};

    rst_n     = 1'b0;
    bus.data1 = '0;
    bus.data2 = '0;
    idle_inputs();
    tick();
    tick();
    check_all_zero("reset");
    rst_n  = 1'b1;
    mon_en = 1'b1;

    // ---------------- table-driven transfers ----------------
    for (int v = 0; v < 8; v++) begin
      bus.send1 = vecs[v].s1;
      bus.send2 = vecs[v].s2;
      bus.data1 = vecs[v].d1;
      bus.data2 = vecs[v].d2;
      e.owner = vecs[v].exp_owner;
      e.data  = vecs[v].exp_data;
      sb_q.push_back(e);
      tick();
      check($sformatf("v%0d_bus_send", v), {31'd0, bus.bus_send}, 32'd1);
      check($sformatf("v%0d_busy", v), {31'd0, bus.busy}, 32'd1);
      sb_pop($sformatf("v%0d", v));
      tick();
      tick();
      check($sformatf("v%0d_hold_send", v), {31'd0, bus.bus_send}, 32'd1);
      check($sformatf("v%0d_hold_data", v), {16'd0, bus.bus_data}, {16'd0, vecs[v].exp_data});
      bus.bus_ack = 1'b1;  // third bus_send cycle
      tick();
      check($sformatf("v%0d_send_drop", v), {31'd0, bus.bus_send}, 32'd0);
      check($sformatf("v%0d_data_clr", v), {16'd0, bus.bus_data}, 32'd0);
      check($sformatf("v%0d_acks", v), {30'd0, bus.ack1, bus.ack2},
            vecs[v].exp_owner ? 32'd1 : 32'd2);
      bus.bus_ack = 1'b0;
      tick();
      check($sformatf("v%0d_ack_held", v), {30'd0, bus.ack1, bus.ack2},
            vecs[v].exp_owner ? 32'd1 : 32'd2);
      bus.send1 = 1'b0;
      bus.send2 = 1'b0;
      tick();
      check($sformatf("v%0d_ack_clr", v), {30'd0, bus.ack1, bus.ack2}, 32'd0);
      check($sformatf("v%0d_idle", v), {31'd0, bus.busy}, 32'd0);
    end

    // ---------------- strict alternation, both requesting ----------------
    do_reset();
    bus.data1 = 16'h0001;
    bus.data2 = 16'h0002;
    for (int i = 0; i < 4; i++) begin
      e.owner = i[0];
      e.data  = i[0] ? 16'h0002 : 16'h0001;
      sb_q.push_back(e);
    end
    bus.send1 = 1'b1;
    bus.send2 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      wait_bus_send($sformatf("alt%0d", i));
      sb_pop($sformatf("alt%0d", i));
      bus.bus_ack = 1'b1;
      tick();
      // winner drops send on ack, consumer drops bus_ack on bus_send low
      if (bus.ack1) bus.send1 = 1'b0;
      if (bus.ack2) bus.send2 = 1'b0;
      bus.bus_ack = 1'b0;
      tick();
      check($sformatf("alt%0d_idle_gap", i), {31'd0, bus.busy}, 32'd0);
      bus.send1 = 1'b1;
      bus.send2 = 1'b1;
    end
    bus.send1 = 1'b0;
    bus.send2 = 1'b0;
    tick();
    check("alt_sb_drained", sb_q.size(), 32'd0);

    // ---------------- reset while in GRANT ----------------
    do_reset();
    bus.send1 = 1'b1;
    bus.data1 = 16'h3C3C;
    tick();
    check("rst_grant_bus_send", {31'd0, bus.bus_send}, 32'd1);
    rst_n = 1'b0;
    bus.send1 = 1'b0;
    tick();
    rst_n = 1'b1;
    check_all_zero("rst_grant");
    // requester 1 went last, but reset restores its tie priority
    bus.send1 = 1'b1;
    bus.send2 = 1'b1;
    bus.data1 = 16'h0101;
    bus.data2 = 16'h0202;
    e.owner = 1'b0;
    e.data  = 16'h0101;
    sb_q.push_back(e);
    tick();
    sb_pop("rst_tie");
    bus.bus_ack = 1'b1;
    tick();
    bus.send1   = 1'b0;
    bus.send2   = 1'b0;
    bus.bus_ack = 1'b0;
    tick();
    check("rst_tie_done", {31'd0, bus.busy}, 32'd0);

    // ---------------- bus_ack while IDLE ----------------
    bus.bus_ack = 1'b1;
    tick();
    bus.bus_ack = 1'b0;
    check_all_zero("idle_ack_a");
    tick();
    check_all_zero("idle_ack_b");

    // ---------------- GRANT timeout ----------------
    do_reset();
    bus.send2 = 1'b1;
    bus.data2 = 16'h5A5A;
    tick();
    cnt = 0;
`ifdef ARB_TIMEOUT_EN
    while (bus.bus_send === 1'b1 && cnt < 20) begin
      cnt++;
      tick();
    end
    check("to_cycles", cnt, TO);
    check("to_ack2", {30'd0, bus.ack1, bus.ack2}, 32'd1);
    check("to_terr", {31'd0, bus.timeout_err}, 32'd1);
    check("to_data_clr", {16'd0, bus.bus_data}, 32'd0);
    bus.send2 = 1'b0;
    tick();
    check("to_release", {31'd0, bus.busy}, 32'd0);
    bus.send1 = 1'b1;
    bus.data1 = 16'h0F0F;
    tick();
    check("to_next_data", {16'd0, bus.bus_data}, 32'h0000_0F0F);
    bus.bus_ack = 1'b1;
    tick();
    check("to_next_ack1", {30'd0, bus.ack1, bus.ack2}, 32'd2);
    check("to_terr_sticky", {31'd0, bus.timeout_err}, 32'd1);
    bus.send1   = 1'b0;
    bus.bus_ack = 1'b0;
    tick();
`else
    for (int i = 0; i < 120; i++) begin
      if (bus.bus_send === 1'b1) cnt++;
      tick();
    end
    check("nto_cycles", cnt, 32'd120);
    check("nto_terr", {31'd0, bus.timeout_err}, 32'd0);
    check("nto_data", {16'd0, bus.bus_data}, 32'h0000_5A5A);
    bus.bus_ack = 1'b1;
    tick();
    check("nto_ack2", {30'd0, bus.ack1, bus.ack2}, 32'd1);
    bus.send2   = 1'b0;
    bus.bus_ack = 1'b0;
    tick();
    check("nto_release", {31'd0, bus.busy}, 32'd0);
`endif

    mon_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
